usbfs_endp_tx_pkt: RTL and testbench

USB full-speed IN-endpoint transmitter with packet buffering and retransmission. It collects bytes from an upstream valid/ready stream into a MAX_PKT-byte packet buffer and closes packets on i_last or full. It streams the packet into the u_tx write-buffer interface each time the host issues IN, and holds the packet until ACK so it can be retransmitted on timeout. It tracks the DATA0/DATA1 toggle, supports STALL, and optionally appends a terminating zero-length packet (ZLP). It sits between the endpoint application logic and the shared usbfs transmitter.

---
 rtl/usbfs_endp_tx_pkt.sv | 183 ++++++++++++++++++
 tb/tb_usbfs_endp_tx_pkt.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usbfs_endp_tx_pkt.sv
// -----------------------------------------------------------------------------
// usbfs_endp_tx_pkt
// USB full-speed IN-endpoint transmitter with a single packet buffer.
// Bytes from an upstream valid/ready stream are collected into a MAX_PKT-byte
// buffer. A packet closes on i_last or when the buffer is full. Each IN that
// u_tx accepts streams the packet into the u_tx write buffer. The packet is
// held until the host ACKs it, so a handshake timeout leads to a
// retransmission of the same bytes with the same DATA0/DATA1 PID.
//
// Ports
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   o_ready/i_valid/i_data/i_last   upstream byte stream (i_last ends a transfer)
//   i_etReady                ACK received from the host
//   o_etValid                data available (0 = NAK)
//   o_etStall                endpoint halted
//   o_etPid1                 toggle for the next data packet (1 = DATA1)
//   o_etLen                  byte count of the current packet
//   i_etTxAccepted           pulse: DATA PID sent by u_tx
//   i_etTimeout              pulse: handshake timeout, no ACK
//   o_etWrEn/o_etWrIdx/o_etWrByte   write port into the u_tx buffer
//   i_stallSet/i_stallClr    halt / un-halt (un-halt also resets the toggle)
// -----------------------------------------------------------------------------
module usbfs_endp_tx_pkt #(
  parameter int MAX_PKT                = 8,
  parameter bit NAK_NOT_ZEROLENGTHDATA = 1'b0,
  parameter bit ZLP_AFTER_MAX          = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  output logic                         o_ready,
  input  logic                         i_valid,
  input  logic [7:0]                   i_data,
  input  logic                         i_last,
  input  logic                         i_etReady,
  output logic                         o_etValid,
  output logic                         o_etStall,
  output logic                         o_etPid1,
  output logic [$clog2(MAX_PKT+1)-1:0] o_etLen,
  input  logic                         i_etTxAccepted,
  input  logic                         i_etTimeout,
  output logic                         o_etWrEn,
  output logic [$clog2(MAX_PKT)-1:0]   o_etWrIdx,
  output logic [7:0]                   o_etWrByte,
  input  logic                         i_stallSet,
  input  logic                         i_stallClr
);

  localparam int CW = $clog2(MAX_PKT + 1);
  localparam int IW = $clog2(MAX_PKT);

  typedef enum logic [1:0] {
    S_FILL,
    S_READY,
    S_SEND,
    S_WAIT_ACK
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_idx;
  logic            r_toggle;
  logic            r_stall;
  logic            r_zlp_pend;
  logic [7:0]      r_buf [MAX_PKT];

  logic            w_idle_zlp;
  logic            w_valid;
  logic            w_tx_go;
  logic            w_push;
  logic            w_close;
  logic            w_ack;
  logic            w_abort;
  logic            w_send_done;
  logic            w_wr_en;

  // An empty buffer in FILL answers IN with a zero-length packet unless the
  // endpoint is configured to NAK instead.
  assign w_idle_zlp  = (r_state == S_FILL) && (r_count == '0) && !NAK_NOT_ZEROLENGTHDATA;
  assign w_valid     = !r_stall && ((r_state != S_FILL) || w_idle_zlp);
  assign w_tx_go     = i_etTxAccepted && !r_stall && ((r_state == S_READY) || w_idle_zlp);
  // A push in the same cycle the idle ZLP starts sending is refused (o_ready
  // low) so the byte is not lost behind a zero-length packet.
  assign w_push      = i_valid && (r_state == S_FILL) && !w_tx_go;
  assign w_close     = w_push && (i_last || (r_count == CW'(MAX_PKT - 1)));
  assign w_ack       = (r_state == S_WAIT_ACK) && i_etReady && w_valid;
  assign w_abort     = (i_stallSet || r_stall) && ((r_state == S_SEND) || (r_state == S_WAIT_ACK));
  assign w_send_done = (r_state == S_SEND) && ((r_count == '0) || (r_idx == r_count - CW'(1)));
  assign w_wr_en     = (r_state == S_SEND) && (r_idx < r_count);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_FILL;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next unassigned,
    // which would otherwise infer a latch.
    w_next = r_state;
    unique case (r_state)
      S_FILL: begin
        if (w_tx_go)      w_next = S_SEND;
        else if (w_close) w_next = S_READY;
      end
      S_READY: begin
        if (w_tx_go) w_next = S_SEND;
      end
      S_SEND: begin
        if (w_abort)          w_next = S_READY;
        else if (w_send_done) w_next = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // A received ACK takes precedence over a timeout or a new halt in the
        // same cycle: the host already has the data.
        if (w_ack)            w_next = r_zlp_pend ? S_READY : S_FILL;
        else if (w_abort)     w_next = S_READY;
        else if (i_etTimeout) w_next = S_READY;
      end
      default: w_next = S_FILL;
    endcase
  end

  // Output logic
  always_comb begin
    o_ready    = (r_state == S_FILL) && !w_tx_go;
    o_etValid  = w_valid;
    o_etStall  = r_stall;
    o_etPid1   = r_toggle;
    o_etLen    = r_count;
    o_etWrEn   = w_wr_en;
    o_etWrIdx  = w_wr_en ? r_idx[IW-1:0] : '0;
    o_etWrByte = w_wr_en ? r_buf[r_idx[IW-1:0]] : 8'h00;
  end

  // Control datapath: count, send index, toggle, halt, pending ZLP
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count    <= '0;
      r_idx      <= '0;
      r_toggle   <= 1'b0;
      r_stall    <= 1'b0;
      r_zlp_pend <= 1'b0;
    end else begin
      if (w_push) begin
        r_count <= r_count + CW'(1);
        if (ZLP_AFTER_MAX && i_last && (r_count == CW'(MAX_PKT - 1)))
          r_zlp_pend <= 1'b1;
      end

      if (w_tx_go)                 r_idx <= '0;
      else if (r_state == S_SEND)  r_idx <= r_idx + CW'(1);

      if (w_ack) begin
        r_toggle   <= ~r_toggle;
        r_count    <= '0;
        r_zlp_pend <= 1'b0;
      end

      // Halt set dominates clear; clearing a halt restarts at DATA0.
      if (i_stallSet) begin
        r_stall <= 1'b1;
      end else if (i_stallClr) begin
        r_stall  <= 1'b0;
        r_toggle <= 1'b0;
      end
    end
  end

  // Packet buffer
  // NOTE: the buffer is deliberately not reset; r_count alone says which
  // bytes are meaningful, and leaving the array out of reset lets it map to RAM.
  always_ff @(posedge i_clk) begin
    if (w_push) r_buf[r_count[IW-1:0]] <= i_data;
  end

endmodule

// File: tb/tb_usbfs_endp_tx_pkt.sv
// -----------------------------------------------------------------------------
// tb_usbfs_endp_tx_pkt
// Self-checking bench. The main DUT uses default parameters; a second
// instance with NAK_NOT_ZEROLENGTHDATA=1 shares all inputs and is only
// checked for its NAK behaviour. Expected u_tx write beats are pushed to a
// scoreboard queue when a send is triggered and popped by a monitor that
// samples the write port on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_usbfs_endp_tx_pkt;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] data;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic       i_valid;
  logic [7:0] i_data;
  logic       i_last;
  logic       i_etReady;
  logic       i_etTxAccepted;
  logic       i_etTimeout;
  logic       i_stallSet;
  logic       i_stallClr;

  logic       o_ready, o_etValid, o_etStall, o_etPid1, o_etWrEn;
  logic [3:0] o_etLen;
  logic [2:0] o_etWrIdx;
  logic [7:0] o_etWrByte;

  logic       n_ready, n_etValid, n_etStall, n_etPid1, n_etWrEn;
  logic [3:0] n_etLen;
  logic [2:0] n_etWrIdx;
  logic [7:0] n_etWrByte;

  int         n_checks = 0;
  int         n_pass   = 0;
  beat_t      sb[$];
  logic [7:0] pkt[$];

  usbfs_endp_tx_pkt dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_ready(o_ready), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
    .i_etReady(i_etReady), .o_etValid(o_etValid), .o_etStall(o_etStall),
    .o_etPid1(o_etPid1), .o_etLen(o_etLen), .i_etTxAccepted(i_etTxAccepted),
    .i_etTimeout(i_etTimeout), .o_etWrEn(o_etWrEn), .o_etWrIdx(o_etWrIdx),
    .o_etWrByte(o_etWrByte), .i_stallSet(i_stallSet), .i_stallClr(i_stallClr)
  );

  usbfs_endp_tx_pkt #(.NAK_NOT_ZEROLENGTHDATA(1'b1)) dut_nak (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_ready(n_ready), .i_valid(i_valid), .i_data(i_data), .i_last(i_last),
    .i_etReady(i_etReady), .o_etValid(n_etValid), .o_etStall(n_etStall),
    .o_etPid1(n_etPid1), .o_etLen(n_etLen), .i_etTxAccepted(i_etTxAccepted),
    .i_etTimeout(i_etTimeout), .o_etWrEn(n_etWrEn), .o_etWrIdx(n_etWrIdx),
    .o_etWrByte(n_etWrByte), .i_stallSet(i_stallSet), .i_stallClr(i_stallClr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Write-port monitor: every strobe must match the next expected beat.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && o_etWrEn) begin
      check("wr_expected", {31'b0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("wr_idx",  {29'b0, o_etWrIdx}, {29'b0, e.idx});
        check("wr_byte", {24'b0, o_etWrByte}, {24'b0, e.data});
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    sb.delete();
    pkt.delete();
  endtask

  // Push n bytes base, base+1, ...; i_last on the final one if last is set.
  task automatic push_bytes(input int n, input logic [7:0] base, input bit last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = base + 8'(i);
      i_last  = last && (i == n - 1);
      pkt.push_back(base + 8'(i));
      step();
      i_valid = 1'b0;
      i_last  = 1'b0;
    end
  endtask

  task automatic pulse_tx();
    @(negedge clk) i_etTxAccepted = 1'b1;
    step();
    i_etTxAccepted = 1'b0;
  endtask

  task automatic pulse_ack(input bit with_timeout);
    @(negedge clk);
    i_etReady   = 1'b1;
    i_etTimeout = with_timeout;
    step();
    i_etReady   = 1'b0;
    i_etTimeout = 1'b0;
  endtask

  task automatic pulse_timeout();
    @(negedge clk) i_etTimeout = 1'b1;
    step();
    i_etTimeout = 1'b0;
  endtask

  task automatic pulse_stall(input bit set, input bit clr);
    @(negedge clk);
    i_stallSet = set;
    i_stallClr = clr;
    step();
    i_stallSet = 1'b0;
    i_stallClr = 1'b0;
  endtask

  // Queue the model packet as expected beats, trigger the send and give the
  // DUT a bounded number of cycles to drain them.
  task automatic send_pkt(input string tag);
    for (int i = 0; i < pkt.size(); i++) sb.push_back('{idx: 3'(i), data: pkt[i]});
    pulse_tx();
    repeat (pkt.size() + 1) step();
    check({tag, "_beats_left"}, sb.size(), 0);
    check({tag, "_wr_idle"}, {31'b0, o_etWrEn}, 0);
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_data = 8'h00; i_last = 1'b0;
    i_etReady = 1'b0; i_etTxAccepted = 1'b0; i_etTimeout = 1'b0;
    i_stallSet = 1'b0; i_stallClr = 1'b0;
    #2;
    check("rst_ready",  {31'b0, o_ready}, 1);
    check("rst_valid",  {31'b0, o_etValid}, 1);
    check("rst_nvalid", {31'b0, n_etValid}, 0);
    check("rst_stall",  {31'b0, o_etStall}, 0);
    check("rst_pid",    {31'b0, o_etPid1}, 0);
    check("rst_len",    {28'b0, o_etLen}, 0);
    check("rst_wren",   {31'b0, o_etWrEn}, 0);
    do_reset();

    // 1: short packet closed by i_last
    push_bytes(3, 8'hA1, 1'b1);
    check("t1_len",   {28'b0, o_etLen}, 3);
    check("t1_ready", {31'b0, o_ready}, 0);
    check("t1_valid", {31'b0, o_etValid}, 1);
    send_pkt("t1");
    check("t1_pid_wait", {31'b0, o_etPid1}, 0);
    pulse_ack(1'b0); pkt.delete();
    check("t1_pid_ack", {31'b0, o_etPid1}, 1);
    check("t1_ready2",  {31'b0, o_ready}, 1);
    check("t1_len2",    {28'b0, o_etLen}, 0);

    // 2: full packet ending with i_last is followed by a ZLP
    do_reset();
    push_bytes(8, 8'hB0, 1'b1);
    check("t2_len", {28'b0, o_etLen}, 8);
    send_pkt("t2");
    check("t2_pid0", {31'b0, o_etPid1}, 0);
    pulse_ack(1'b0); pkt.delete();
    check("t2_pid1",     {31'b0, o_etPid1}, 1);
    check("t2_zlp_len",  {28'b0, o_etLen}, 0);
    check("t2_zlp_rdy",  {31'b0, o_ready}, 0);
    check("t2_zlp_vld",  {31'b0, o_etValid}, 1);
    send_pkt("t2z");
    pulse_ack(1'b0);
    check("t2_pid_end",  {31'b0, o_etPid1}, 0);
    check("t2_ready_end",{31'b0, o_ready}, 1);

    // 3: timeout causes retransmission with unchanged PID; ACK beats timeout
    do_reset();
    push_bytes(2, 8'hC0, 1'b1);
    send_pkt("t3a");
    pulse_timeout();
    check("t3_pid_to", {31'b0, o_etPid1}, 0);
    check("t3_len_to", {28'b0, o_etLen}, 2);
    check("t3_rdy_to", {31'b0, o_ready}, 0);
    send_pkt("t3b");
    pulse_ack(1'b1); pkt.delete();
    check("t3_pid_ack", {31'b0, o_etPid1}, 1);
    check("t3_rdy_ack", {31'b0, o_ready}, 1);

    // 4: NAK on empty/partial; full close without i_last queues no ZLP
    do_reset();
    check("t4_nak_empty", {31'b0, n_etValid}, 0);
    push_bytes(1, 8'h40, 1'b0);
    check("t4_nak_part",  {31'b0, n_etValid}, 0);
    check("t4_def_part",  {31'b0, o_etValid}, 0);
    check("t4_nlen1",     {28'b0, n_etLen}, 1);
    push_bytes(7, 8'h41, 1'b0);
    check("t4_nak_full",  {31'b0, n_etValid}, 1);
    check("t4_nlen8",     {28'b0, n_etLen}, 8);
    check("t4_def_rdy",   {31'b0, o_ready}, 0);
    send_pkt("t4");
    pulse_ack(1'b0); pkt.delete();
    check("t4_no_zlp",    {31'b0, o_ready}, 1);
    check("t4_pid",       {31'b0, o_etPid1}, 1);

    // 5: halt during WAIT_ACK, ignored IN, un-halt and resend
    push_bytes(3, 8'hD0, 1'b1);
    send_pkt("t5a");
    pulse_stall(1'b1, 1'b0);
    check("t5_stall", {31'b0, o_etStall}, 1);
    check("t5_valid", {31'b0, o_etValid}, 0);
    pulse_tx();
    repeat (4) step();
    check("t5_no_wr", {31'b0, o_etWrEn}, 0);
    pulse_ack(1'b0);
    check("t5_pid_hold", {31'b0, o_etPid1}, 1);
    pulse_stall(1'b1, 1'b1);
    check("t5_set_wins", {31'b0, o_etStall}, 1);
    pulse_stall(1'b0, 1'b1);
    check("t5_unstall", {31'b0, o_etStall}, 0);
    check("t5_pid_clr", {31'b0, o_etPid1}, 0);
    check("t5_valid2",  {31'b0, o_etValid}, 1);
    check("t5_len",     {28'b0, o_etLen}, 3);
    send_pkt("t5b");
    pulse_ack(1'b0); pkt.delete();
    check("t5_pid_ack", {31'b0, o_etPid1}, 1);

    // 6: reset in the middle of a SEND strobe sequence
    push_bytes(4, 8'hE0, 1'b1);
    for (int i = 0; i < pkt.size(); i++) sb.push_back('{idx: 3'(i), data: pkt[i]});
    pulse_tx();
    @(posedge clk); #2;
    check("t6_wr_mid", {31'b0, o_etWrEn}, 1);
    #1 rst_n = 1'b0;
    #1 check("t6_wr_drop", {31'b0, o_etWrEn}, 0);
    sb.delete(); pkt.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("t6_len",   {28'b0, o_etLen}, 0);
    check("t6_ready", {31'b0, o_ready}, 1);
    check("t6_pid",   {31'b0, o_etPid1}, 0);

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
